// File: rtl/disaster_sensor_conditioner.sv
// Disaster sensor conditioner.
// Quantizes raw rain, seismic, wind and water-level samples into 2-bit
// severity codes. Each channel has downward hysteresis on thresholds it has
// already crossed, and a persistence filter, so isolated noisy samples never
// reach the committed codes that drive the classifier and the LEDs.

// One conditioning channel: quantizer, persistence filter and code register.
module DisasterChannel #(
  parameter int DW      = 8,
  parameter int T1      = 64,
  parameter int T2      = 128,
  parameter int T3      = 192,
  parameter int HYST    = 8,
  parameter int PERSIST = 3,
  parameter int CW      = $clog2(PERSIST + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sampleValid_i,
  input  logic [DW-1:0] raw_i,
  output logic [1:0]    code_o,
  output logic          commit_o
);

  // Entry thresholds apply while the committed code is still below a level.
  // Once a level has been reached, its threshold is relaxed by HYST so that
  // a value sitting just under the threshold does not immediately drop it.
  localparam logic [DW-1:0] Thr1Up = DW'(T1);
  localparam logic [DW-1:0] Thr2Up = DW'(T2);
  localparam logic [DW-1:0] Thr3Up = DW'(T3);
  localparam logic [DW-1:0] Thr1Dn = DW'(T1 - HYST);
  localparam logic [DW-1:0] Thr2Dn = DW'(T2 - HYST);
  localparam logic [DW-1:0] Thr3Dn = DW'(T3 - HYST);

  // A candidate commits when it is seen for the PERSIST-th time in a row,
  // i.e. when the counter already holds PERSIST-1 matching samples.
  localparam logic [CW-1:0] CntLast = CW'(PERSIST - 1);

  logic [1:0]    code_q, code_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q,  cnt_d;

  logic          pass1, pass2, pass3;
  logic [1:0]    quant;

  // Quantize the raw sample against thresholds chosen by the current code.
  // The passes are counted rather than priority-encoded so that any legal
  // threshold/hysteresis combination gives a well-defined level.
  always_comb begin
    pass1 = (code_q >= 2'd1) ? (raw_i >= Thr1Dn) : (raw_i >= Thr1Up);
    pass2 = (code_q >= 2'd2) ? (raw_i >= Thr2Dn) : (raw_i >= Thr2Up);
    pass3 = (code_q >= 2'd3) ? (raw_i >= Thr3Dn) : (raw_i >= Thr3Up);
    quant = {1'b0, pass1} + {1'b0, pass2} + {1'b0, pass3};
  end

  // Persistence filter: a new level must be observed on consecutive valid
  // samples before it replaces the committed code. Idle cycles hold state,
  // so gaps between samples neither advance nor reset the count.
  always_comb begin
    code_d = code_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sampleValid_i) begin
      if (quant == code_q) begin
        cand_d = code_q;
        cnt_d  = '0;
      end else if (quant != cand_q) begin
        cand_d = quant;
        if (PERSIST == 1) begin
          code_d = quant;
          cnt_d  = '0;
        end else begin
          cnt_d  = CW'(1);
        end
      end else begin
        if (cnt_q == CntLast) begin
          code_d = quant;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
        end
      end
    end
    commit_o = sampleValid_i && (code_d != code_q);
  end

  // Filter state register; reset has priority over any sample on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q <= 2'd0;
      cand_q <= 2'd0;
      cnt_q  <= '0;
    end else begin
      code_q <= code_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign code_o = code_q;

endmodule

// Top level: four identical channels plus the shared handshake flags.
module disaster_sensor_conditioner #(
  parameter int DW      = 8,
  parameter int T1      = 64,
  parameter int T2      = 128,
  parameter int T3      = 192,
  parameter int HYST    = 8,
  parameter int PERSIST = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] rain_raw,
  input  logic [DW-1:0] seis_raw,
  input  logic [DW-1:0] wind_raw,
  input  logic [DW-1:0] level_raw,
  output logic          r1,
  output logic          r0,
  output logic          s1,
  output logic          s0,
  output logic          w1,
  output logic          w0,
  output logic          l1,
  output logic          l0,
  output logic          codes_valid,
  output logic          code_changed
);

  logic [1:0] rainCode, seisCode, windCode, levelCode;
  logic       rainCommit, seisCommit, windCommit, levelCommit;

  logic       codesValid_q;
  logic       codeChanged_q;

  DisasterChannel #(
    .DW(DW), .T1(T1), .T2(T2), .T3(T3), .HYST(HYST), .PERSIST(PERSIST)
  ) uRain (
    .clk           (clk),
    .rst_n         (rst_n),
    .sampleValid_i (sample_valid),
    .raw_i         (rain_raw),
    .code_o        (rainCode),
    .commit_o      (rainCommit)
  );

  DisasterChannel #(
    .DW(DW), .T1(T1), .T2(T2), .T3(T3), .HYST(HYST), .PERSIST(PERSIST)
  ) uSeis (
    .clk           (clk),
    .rst_n         (rst_n),
    .sampleValid_i (sample_valid),
    .raw_i         (seis_raw),
    .code_o        (seisCode),
    .commit_o      (seisCommit)
  );

  DisasterChannel #(
    .DW(DW), .T1(T1), .T2(T2), .T3(T3), .HYST(HYST), .PERSIST(PERSIST)
  ) uWind (
    .clk           (clk),
    .rst_n         (rst_n),
    .sampleValid_i (sample_valid),
    .raw_i         (wind_raw),
    .code_o        (windCode),
    .commit_o      (windCommit)
  );

  DisasterChannel #(
    .DW(DW), .T1(T1), .T2(T2), .T3(T3), .HYST(HYST), .PERSIST(PERSIST)
  ) uLevel (
    .clk           (clk),
    .rst_n         (rst_n),
    .sampleValid_i (sample_valid),
    .raw_i         (level_raw),
    .code_o        (levelCode),
    .commit_o      (levelCommit)
  );

  // Handshake flags land on the same edge as the code update they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      codesValid_q  <= 1'b0;
      codeChanged_q <= 1'b0;
    end else begin
      codesValid_q  <= sample_valid;
      codeChanged_q <= rainCommit | seisCommit | windCommit | levelCommit;
    end
  end

  assign {r1, r0}     = rainCode;
  assign {s1, s0}     = seisCode;
  assign {w1, w0}     = windCode;
  assign {l1, l0}     = levelCode;
  assign codes_valid  = codesValid_q;
  assign code_changed = codeChanged_q;

endmodule

// File: tb/tb_disaster_sensor_conditioner.sv
// Testbench for disaster_sensor_conditioner.
// Directed scenarios plus a randomized run; every cycle's expected outputs
// come from a behavioural model and are queued, then compared after the edge.
module tb_disaster_sensor_conditioner;

  localparam int T1      = 64;
  localparam int T2      = 128;
  localparam int T3      = 192;
  localparam int HYST    = 8;
  localparam int PERSIST = 3;

  logic       clk = 1'b0;
  logic       rstN;
  logic       sampleValid;
  logic [7:0] rainRaw, seisRaw, windRaw, levelRaw;
  logic       r1, r0, s1, s0, w1, w0, l1, l0;
  logic       codesValid, codeChanged;
  logic [7:0] dutCodes;

  typedef struct packed {
    logic [7:0] codes;
    logic       cv;
    logic       chg;
  } sbEntry_t;

  sbEntry_t sbQ[$];

  int mCode[4];
  int mCand[4];
  int mCnt[4];

  int checkCount = 0;
  int passCount  = 0;
  int cvCount;
  int chgCount;

  logic [7:0] pick [16];

  disaster_sensor_conditioner dut (
    .clk          (clk),
    .rst_n        (rstN),
    .sample_valid (sampleValid),
    .rain_raw     (rainRaw),
    .seis_raw     (seisRaw),
    .wind_raw     (windRaw),
    .level_raw    (levelRaw),
    .r1           (r1),
    .r0           (r0),
    .s1           (s1),
    .s0           (s0),
    .w1           (w1),
    .w0           (w0),
    .l1           (l1),
    .l0           (l0),
    .codes_valid  (codesValid),
    .code_changed (codeChanged)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  assign dutCodes = {r1, r0, s1, s0, w1, w0, l1, l0};

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  // Severity level of a raw value given the currently committed code.
  function automatic int quantize(input int raw, input int code);
    int thr[3];
    int n;
    thr = '{T1, T2, T3};
    n = 0;
    for (int i = 0; i < 3; i++) begin
      int lim;
      lim = (code >= i + 1) ? thr[i] - HYST : thr[i];
      if (raw >= lim) n++;
    end
    return n;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected result
  // and return just after the edge on which the DUT takes the inputs.
  task automatic applyStimulus(input logic rst, input logic v,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
    sbEntry_t e;
    int raws[4];
    int q;
    logic changed;
    @(negedge clk);
    rstN        = rst;
    sampleValid = v;
    rainRaw     = a;
    seisRaw     = b;
    windRaw     = c;
    levelRaw    = d;
    raws = '{int'(a), int'(b), int'(c), int'(d)};
    changed = 1'b0;
    if (!rst) begin
      for (int ch = 0; ch < 4; ch++) begin
        mCode[ch] = 0;
        mCand[ch] = 0;
        mCnt[ch]  = 0;
      end
      e.cv = 1'b0;
    end else if (v) begin
      for (int ch = 0; ch < 4; ch++) begin
        q = quantize(raws[ch], mCode[ch]);
        if (q == mCode[ch]) begin
          mCand[ch] = mCode[ch];
          mCnt[ch]  = 0;
        end else if (q != mCand[ch]) begin
          mCand[ch] = q;
          mCnt[ch]  = 1;
          if (PERSIST == 1) begin
            mCode[ch] = q;
            mCnt[ch]  = 0;
            changed   = 1'b1;
          end
        end else if (mCnt[ch] + 1 == PERSIST) begin
          mCode[ch] = q;
          mCnt[ch]  = 0;
          changed   = 1'b1;
        end else begin
          mCnt[ch]++;
        end
      end
      e.cv = 1'b1;
    end else begin
      e.cv = 1'b0;
    end
    e.chg   = changed;
    e.codes = {2'(mCode[0]), 2'(mCode[1]), 2'(mCode[2]), 2'(mCode[3])};
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: after every edge, compare the DUT against the oldest entry.
  always @(posedge clk) begin
    sbEntry_t e;
    #1;
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput("sb_codes", 32'(dutCodes), 32'(e.codes));
      checkOutput("sb_codes_valid", 32'(codesValid), 32'(e.cv));
      checkOutput("sb_code_changed", 32'(codeChanged), 32'(e.chg));
    end
  end

  // Directed scenarios, then random traffic, then the summary.
  initial begin
    pick = '{8'd0, 8'd55, 8'd56, 8'd63, 8'd64, 8'd100, 8'd119, 8'd120,
             8'd127, 8'd128, 8'd150, 8'd183, 8'd184, 8'd191, 8'd192, 8'd255};
    rstN = 1'b0;
    sampleValid = 1'b1;
    rainRaw = 8'd255; seisRaw = 8'd255; windRaw = 8'd255; levelRaw = 8'd255;

    // Reset held with full-scale valid samples.
    repeat (2) applyStimulus(1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255);
    checkOutput("reset_codes", 32'(dutCodes), 32'h0);
    checkOutput("reset_cv", 32'(codesValid), 32'h0);
    checkOutput("reset_chg", 32'(codeChanged), 32'h0);

    // Persistence on rain.
    applyStimulus(1'b1, 1'b1, 8'd130, 8'd0, 8'd0, 8'd0);
    checkOutput("persist_r_s1", 32'({r1, r0}), 32'h0);
    checkOutput("persist_cv_s1", 32'(codesValid), 32'h1);
    applyStimulus(1'b1, 1'b1, 8'd130, 8'd0, 8'd0, 8'd0);
    checkOutput("persist_r_s2", 32'({r1, r0}), 32'h0);
    applyStimulus(1'b1, 1'b1, 8'd130, 8'd0, 8'd0, 8'd0);
    checkOutput("persist_r_s3", 32'({r1, r0}), 32'h2);
    checkOutput("persist_cv_s3", 32'(codesValid), 32'h1);
    checkOutput("persist_chg_s3", 32'(codeChanged), 32'h1);

    // Glitch rejection on seismic.
    applyStimulus(1'b1, 1'b1, 8'd130, 8'd200, 8'd0, 8'd0);
    applyStimulus(1'b1, 1'b1, 8'd130, 8'd200, 8'd0, 8'd0);
    applyStimulus(1'b1, 1'b1, 8'd130, 8'd0,   8'd0, 8'd0);
    applyStimulus(1'b1, 1'b1, 8'd130, 8'd200, 8'd0, 8'd0);
    applyStimulus(1'b1, 1'b1, 8'd130, 8'd200, 8'd0, 8'd0);
    checkOutput("glitch_s_s5", 32'({s1, s0}), 32'h0);
    applyStimulus(1'b1, 1'b1, 8'd130, 8'd200, 8'd0, 8'd0);
    checkOutput("glitch_s_s6", 32'({s1, s0}), 32'h3);

    // Hysteresis on wind.
    repeat (3) applyStimulus(1'b1, 1'b1, 8'd130, 8'd200, 8'd150, 8'd0);
    checkOutput("hyst_w_up", 32'({w1, w0}), 32'h2);
    repeat (3) applyStimulus(1'b1, 1'b1, 8'd130, 8'd200, 8'd122, 8'd0);
    checkOutput("hyst_w_hold", 32'({w1, w0}), 32'h2);
    repeat (2) applyStimulus(1'b1, 1'b1, 8'd130, 8'd200, 8'd119, 8'd0);
    checkOutput("hyst_w_drop_s2", 32'({w1, w0}), 32'h2);
    applyStimulus(1'b1, 1'b1, 8'd130, 8'd200, 8'd119, 8'd0);
    checkOutput("hyst_w_drop_s3", 32'({w1, w0}), 32'h1);

    // Gapped valid pulses on level.
    cvCount = 0;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b1, 1'b1, 8'd130, 8'd200, 8'd119, 8'd255);
      if (codesValid) cvCount++;
      if (p < 2) begin
        checkOutput("gap_l_early", 32'({l1, l0}), 32'h0);
        for (int g = 0; g < 5; g++) begin
          applyStimulus(1'b1, 1'b0, 8'd130, 8'd200, 8'd119, 8'd255);
          if (codesValid) cvCount++;
        end
      end
    end
    checkOutput("gap_l_final", 32'({l1, l0}), 32'h3);
    checkOutput("gap_cv_count", 32'(cvCount), 32'd3);

    // All channels back to zero, then a simultaneous rise to code 1.
    repeat (3) applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    checkOutput("sim_zeroed", 32'(dutCodes), 32'h0);
    chgCount = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 8'd100, 8'd100, 8'd100, 8'd100);
      if (codeChanged) chgCount++;
      if (i == 1) checkOutput("sim_codes_s2", 32'(dutCodes), 32'h0);
    end
    checkOutput("sim_codes_s3", 32'(dutCodes), 32'h55);
    checkOutput("sim_chg_count", 32'(chgCount), 32'd1);

    // Reset in the middle of a persistence sequence clears the counters.
    repeat (3) applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    applyStimulus(1'b1, 1'b1, 8'd100, 8'd100, 8'd100, 8'd100);
    applyStimulus(1'b0, 1'b1, 8'd100, 8'd100, 8'd100, 8'd100);
    checkOutput("midrst_codes", 32'(dutCodes), 32'h0);
    checkOutput("midrst_cv", 32'(codesValid), 32'h0);
    applyStimulus(1'b1, 1'b1, 8'd100, 8'd100, 8'd100, 8'd100);
    applyStimulus(1'b1, 1'b1, 8'd100, 8'd100, 8'd100, 8'd100);
    checkOutput("midrst_hold", 32'(dutCodes), 32'h0);
    applyStimulus(1'b1, 1'b1, 8'd100, 8'd100, 8'd100, 8'd100);
    checkOutput("midrst_commit", 32'(dutCodes), 32'h55);

    // Random traffic around the thresholds, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                    pick[$urandom_range(0, 15)], pick[$urandom_range(0, 15)],
                    pick[$urandom_range(0, 15)], pick[$urandom_range(0, 15)]);
    end

    @(posedge clk);
    #2;
    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
